// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the async FIFO: write strobe, binary/Gray write pointer, full, level and sticky overflow.
// Optional almost-full output is built only when FIFO_ALMOST_FULL_EN is defined.
module fifo_wr_ctrl #(
   parameter int ADDR_WIDTH = 3,
   parameter int AF_THRESH  = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  w_inc,
   input  logic [ADDR_WIDTH:0]   wq2_rptr,
   input  logic                  ovf_clr,
   output logic                  w_en,
   output logic [ADDR_WIDTH-1:0] w_addr,
   output logic [ADDR_WIDTH:0]   w_gray_ptr,
   output logic                  w_full,
   output logic [ADDR_WIDTH:0]   w_level,
   output logic                  w_ovf
`ifdef FIFO_ALMOST_FULL_EN
   ,
   output logic                  w_almost_full
`endif
);

   localparam int PW = ADDR_WIDTH + 1;

   typedef enum logic {
      ST_OK  = 1'b0,
      ST_OVF = 1'b1
   } ovf_state_t;

   // The full test below inverts the two top Gray bits, so at least two are needed.
   if (ADDR_WIDTH < 2) begin : g_addr_width_check
      $error("fifo_wr_ctrl: ADDR_WIDTH must be at least 2");
   end
   if (AF_THRESH < 0 || AF_THRESH > (1 << ADDR_WIDTH)) begin : g_af_thresh_check
      $error("fifo_wr_ctrl: AF_THRESH must lie within 0..2**ADDR_WIDTH");
   end

   function automatic logic [ADDR_WIDTH:0] bin2gray(input logic [ADDR_WIDTH:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
      logic [ADDR_WIDTH:0] b;
      b[ADDR_WIDTH] = g[ADDR_WIDTH];
      for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [ADDR_WIDTH:0] bin_p1;
   logic [ADDR_WIDTH:0] next_bin_p0;
   logic [ADDR_WIDTH:0] next_gray_p0;
   logic [ADDR_WIDTH:0] next_level_p0;
   logic [ADDR_WIDTH:0] full_gray_p0;
   logic                next_full_p0;
   ovf_state_t          ovf_state;
   ovf_state_t          ovf_state_nxt;

   // Stage p0: combinational write decision and next-pointer arithmetic
   assign w_en          = w_inc & ~w_full;
   assign w_addr        = bin_p1[ADDR_WIDTH-1:0];
   assign next_bin_p0   = bin_p1 + PW'(w_en);
   assign next_gray_p0  = bin2gray(next_bin_p0);
   // Full means the write pointer is exactly one lap ahead of the synced read pointer.
   assign full_gray_p0  = {~wq2_rptr[ADDR_WIDTH:ADDR_WIDTH-1], wq2_rptr[ADDR_WIDTH-2:0]};
   assign next_full_p0  = (next_gray_p0 == full_gray_p0);
   assign next_level_p0 = next_bin_p0 - gray2bin(wq2_rptr);

   // Stage p1: registered pointer and status flags
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bin_p1     <= '0;
         w_gray_ptr <= '0;
         w_full     <= 1'b0;
         w_level    <= '0;
      end else begin
         bin_p1     <= next_bin_p0;
         w_gray_ptr <= next_gray_p0;
         w_full     <= next_full_p0;
         w_level    <= next_level_p0;
      end
   end

`ifdef FIFO_ALMOST_FULL_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         w_almost_full <= 1'b0;
      end else begin
         w_almost_full <= (next_level_p0 >= PW'(AF_THRESH));
      end
   end
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf_state <= ST_OK;
      end else begin
         ovf_state <= ovf_state_nxt;
      end
   end

   // A fresh overflow in the same cycle as ovf_clr keeps the flag set.
   always_comb begin
      ovf_state_nxt = ovf_state;
      case (ovf_state)
         ST_OK:   if (w_inc && w_full) ovf_state_nxt = ST_OVF;
         ST_OVF:  if (ovf_clr && !(w_inc && w_full)) ovf_state_nxt = ST_OK;
         default: ovf_state_nxt = ST_OK;
      endcase
   end

   assign w_ovf = (ovf_state == ST_OVF);

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Scoreboard bench for fifo_wr_ctrl (ADDR_WIDTH=3): stimulus pushes expected responses, a negedge monitor compares.
module tb_fifo_wr_ctrl;

   typedef struct {
      logic       en;
      logic [2:0] addr;
      logic [3:0] gray;
      logic       full;
      logic [3:0] level;
      logic       ovf;
      logic       af;
   } exp_t;

   logic       clk;
   logic       rst;
   logic       w_inc;
   logic [3:0] wq2_rptr;
   logic       ovf_clr;
   logic       w_en;
   logic [2:0] w_addr;
   logic [3:0] w_gray_ptr;
   logic       w_full;
   logic [3:0] w_level;
   logic       w_ovf;
`ifdef FIFO_ALMOST_FULL_EN
   logic       w_almost_full;
`endif

   fifo_wr_ctrl #(
      .ADDR_WIDTH (3),
      .AF_THRESH  (6)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .w_inc      (w_inc),
      .wq2_rptr   (wq2_rptr),
      .ovf_clr    (ovf_clr),
      .w_en       (w_en),
      .w_addr     (w_addr),
      .w_gray_ptr (w_gray_ptr),
      .w_full     (w_full),
      .w_level    (w_level),
      .w_ovf      (w_ovf)
`ifdef FIFO_ALMOST_FULL_EN
      ,
      .w_almost_full (w_almost_full)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hand-written 4-bit Gray code sequence.
   logic [3:0] gtab [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                             4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

   exp_t q [$];
   int   n_vec  = 0;
   int   n_miss = 0;

   // Reference state: total writes/frees as plain counts, plus registered flags.
   int   m_wr, m_rd, m_level;
   bit   m_full, m_ovf, m_af;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
      if (act !== req) begin
         n_miss++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
      end
   endtask

   exp_t mon_e;
   always @(negedge clk) begin
      if (q.size() > 0) begin
         mon_e = q.pop_front();
         n_vec++;
         chk("w_en",       8'(w_en),       8'(mon_e.en));
         chk("w_addr",     8'(w_addr),     8'(mon_e.addr));
         chk("w_gray_ptr", 8'(w_gray_ptr), 8'(mon_e.gray));
         chk("w_full",     8'(w_full),     8'(mon_e.full));
         chk("w_level",    8'(w_level),    8'(mon_e.level));
         chk("w_ovf",      8'(w_ovf),      8'(mon_e.ovf));
`ifdef FIFO_ALMOST_FULL_EN
         chk("w_almost_full", 8'(w_almost_full), 8'(mon_e.af));
`endif
      end
   end

   task automatic model_clear();
      m_wr = 0; m_rd = 0; m_level = 0;
      m_full = 0; m_ovf = 0; m_af = 0;
   endtask

   // Async reset asserted mid-cycle; outputs must already be zero at the following negedge.
   task automatic do_reset();
      exp_t e;
      @(posedge clk); #1;
      rst = 1'b0; w_inc = 1'b0; ovf_clr = 1'b0; wq2_rptr = 4'h0;
      model_clear();
      e = '{en: 1'b0, addr: 3'd0, gray: 4'h0, full: 1'b0, level: 4'd0, ovf: 1'b0, af: 1'b0};
      q.push_back(e);
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   // One clock of stimulus; expectation covers combinational outputs for these inputs and
   // registered outputs from the previous edge, then the reference advances over the next edge.
   task automatic cyc(input bit inc, input bit clr);
      exp_t e;
      bit   en;
      @(posedge clk); #1;
      w_inc = inc; ovf_clr = clr; wq2_rptr = gtab[m_rd % 16];
      en = inc && !m_full;
      e.en = en;
      e.addr = 3'(m_wr % 8);
      e.gray = gtab[m_wr % 16];
      e.full = m_full;
      e.level = 4'(m_level);
      e.ovf = m_ovf;
      e.af = m_af;
      q.push_back(e);
      if (inc && m_full) m_ovf = 1;
      else if (clr)      m_ovf = 0;
      if (en) m_wr++;
      m_level = m_wr - m_rd;
      m_full  = (m_level == 8);
      m_af    = (m_level >= 6);
   endtask

   initial begin
      rst = 1'b0; w_inc = 1'b0; ovf_clr = 1'b0; wq2_rptr = 4'h0;
      model_clear();
      do_reset();

      // Reset in the middle of a write burst, then first write lands at address 0.
      repeat (3) cyc(1, 0);
      do_reset();
      cyc(1, 0);
      cyc(0, 0);

      // Fill all 8 entries: addresses 0..7, Gray 1,3,2,6,7,5,4,C.
      do_reset();
      repeat (8) cyc(1, 0);
      cyc(0, 0);

      // Write while full, clear, then overflow and clear in the same cycle.
      cyc(1, 0);
      cyc(0, 1);
      cyc(0, 0);
      cyc(1, 1);
      cyc(0, 1);
      cyc(0, 0);

      // One slot freed by the read side, then refilled.
      m_rd++;
      cyc(0, 0);
      cyc(0, 0);
      cyc(1, 0);
      cyc(0, 0);

      // Alternate free/write past the pointer wrap, plus simultaneous write and free.
      for (int i = 0; i < 10; i++) begin
         m_rd++;
         cyc(0, 0);
         cyc(1, 0);
      end
      m_rd++;
      cyc(0, 0);
      m_rd++;
      cyc(1, 0);
      cyc(0, 0);
      m_rd++;
      cyc(1, 0);
      cyc(1, 0);
      cyc(0, 0);

`ifdef FIFO_ALMOST_FULL_EN
      // Almost-full rises once level reaches 6 and falls at 5.
      do_reset();
      repeat (6) cyc(1, 0);
      cyc(0, 0);
      m_rd++;
      cyc(0, 0);
      cyc(0, 0);
`endif

      for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
      if (q.size() != 0) begin
         n_miss++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
      end
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
